// File: rtl/synaptic_input_integrator_if.sv
// rtl/synaptic_input_integrator_if.sv - timestep handshake, weight write and current output bundle
interface synaptic_input_integrator_if #(
   parameter int N_PRE = 16,
   parameter int AW    = 4
);
   logic [N_PRE-1:0] fired_vec;
   logic             step_valid;
   logic             step_ready;
   logic [16:0]      bias;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [16:0]      wr_data;
   logic [16:0]      i_out;
   logic             i_valid;
   logic             busy;

   modport master (
      output fired_vec, step_valid, bias, wr_en, wr_addr, wr_data,
      input  step_ready, i_out, i_valid, busy
   );

   modport slave (
      input  fired_vec, step_valid, bias, wr_en, wr_addr, wr_data,
      output step_ready, i_out, i_valid, busy
   );
endinterface

// File: rtl/synaptic_input_integrator.sv
// rtl/synaptic_input_integrator.sv - serial spike-weighted current accumulator, one result per timestep
// Optional leaky carry-over of the previous current: SYN_LEAK_DECAY_EN.
module synaptic_input_integrator #(
   parameter int N_PRE     = 16,
   parameter int AW        = 4,
   parameter int TAU_SHIFT = 2
) (
   input logic                      clk,
   input logic                      asyn_reset,
   synaptic_input_integrator_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(N_PRE - 1);

   state_t           state_q, state_d;
   logic [N_PRE-1:0] spk_q, spk_d;
   logic [16:0]      acc_q, acc_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [16:0]      i_out_q, i_out_d;
   logic             i_valid_q, i_valid_d;
   logic [16:0]      w_q [N_PRE];
   logic [16:0]      start_acc;
   logic [17:0]      scan_sum;

   // Clamp an 18-bit sum of two 17-bit values back onto the 17-bit rails.
   function automatic logic [16:0] sat17(input logic [17:0] s);
      if (s[17] != s[16]) begin
         return s[17] ? 17'h10000 : 17'h0FFFF;
      end
      return s[16:0];
   endfunction

   assign scan_sum = {acc_q[16], acc_q} + {w_q[idx_q][16], w_q[idx_q]};

`ifdef SYN_LEAK_DECAY_EN
   logic [16:0]        leak_q;
   logic signed [18:0] leak_sum;

   assign leak_q   = $signed(i_out_q) >>> TAU_SHIFT;
   assign leak_sum = $signed({{2{i_out_q[16]}}, i_out_q})
                   + $signed({{2{bus.bias[16]}}, bus.bias})
                   - $signed({{2{leak_q[16]}}, leak_q});
   assign start_acc = (leak_sum > 19'sh0FFFF)  ? 17'h0FFFF :
                      (leak_sum < -19'sh10000) ? 17'h10000 : leak_sum[16:0];
`else
   assign start_acc = bus.bias;
`endif

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state_q   <= IDLE;
         spk_q     <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         i_out_q   <= '0;
         i_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         spk_q     <= spk_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         i_out_q   <= i_out_d;
         i_valid_q <= i_valid_d;
      end
   end

   // Writes land on the edge, so a scan reading the same slot still sees the old weight.
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         for (int k = 0; k < N_PRE; k++) begin
            w_q[k] <= '0;
         end
      end else if (bus.wr_en) begin
         w_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      spk_d     = spk_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      i_out_d   = i_out_q;
      i_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.step_valid) begin
               spk_d   = bus.fired_vec;
               acc_d   = start_acc;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (spk_q[idx_q]) begin
               acc_d = sat17(scan_sum);
            end
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            i_out_d   = acc_q;
            i_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.step_ready = (state_q == IDLE);
   assign bus.busy       = (state_q == SCAN);
   assign bus.i_out      = i_out_q;
   assign bus.i_valid    = i_valid_q;
endmodule

// File: tb/tb_synaptic_input_integrator.sv
// tb/tb_synaptic_input_integrator.sv - directed and randomized checks against a behavioural current model
module tb_synaptic_input_integrator;
   localparam int N_PRE = 16;
   localparam int AW    = 4;
   localparam int LAT   = N_PRE + 1;

   logic clk;
   logic asyn_reset;
   int   checks;
   int   errors;
   int   wm [N_PRE];

   synaptic_input_integrator_if #(.N_PRE(N_PRE), .AW(AW)) bus ();

   synaptic_input_integrator #(.N_PRE(N_PRE), .AW(AW), .TAU_SHIFT(2)) dut (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: bias plus each fired weight in index order, clamped to the rails after every add.
   function automatic logic [16:0] model(input logic [N_PRE-1:0] fv, input logic [16:0] b);
      int acc;
      acc = int'($signed(b));
      for (int k = 0; k < N_PRE; k++) begin
         if (fv[k]) begin
            acc = acc + wm[k];
            if (acc > 65535)  acc = 65535;
            if (acc < -65536) acc = -65536;
         end
      end
      return 17'(acc);
   endfunction

   task automatic write_w(input int a, input logic [16:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
      wm[a]       = int'($signed(d));
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.i_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_step(input logic [N_PRE-1:0] fv, input logic [16:0] b,
                           output logic [16:0] res, output int lat);
      int guard;
      guard = 0;
      while (!bus.step_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.fired_vec  = fv;
      bus.bias       = b;
      bus.step_valid = 1'b1;
      @(posedge clk); #1;
      bus.step_valid = 1'b0;
      bus.fired_vec  = N_PRE'($urandom);
      bus.bias       = 17'($urandom);
      wait_valid(lat);
      res = bus.i_out;
   endtask

   initial begin
      logic [16:0]      res;
      logic [16:0]      exp_v;
      logic [N_PRE-1:0] fv;
      logic [16:0]      b;
      int               lat;
      int               gap;
      int               pulses;

      checks = 0;
      errors = 0;
      for (int k = 0; k < N_PRE; k++) wm[k] = 0;
      asyn_reset     = 1'b1;
      bus.fired_vec  = '0;
      bus.step_valid = 1'b0;
      bus.bias       = '0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_i_out", 32'(bus.i_out), 32'h0);
      check("reset_i_valid", 32'(bus.i_valid), 32'h0);
      check("reset_step_ready", 32'(bus.step_ready), 32'h1);
      check("reset_busy", 32'(bus.busy), 32'h0);
      asyn_reset = 1'b0;
      @(posedge clk); #1;

      write_w(3, 17'h00200);
      run_step(16'h0008, 17'h00100, res, lat);
      check("single_i_out", 32'(res), 32'h00300);
      check("single_latency", 32'(lat), 32'(LAT));
      check("single_ready_after", 32'(bus.step_ready), 32'h1);
      check("single_busy_after", 32'(bus.busy), 32'h0);
      @(posedge clk); #1;
      check("single_valid_one_cycle", 32'(bus.i_valid), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("single_i_out_held", 32'(bus.i_out), 32'h00300);

      for (int k = 0; k < N_PRE; k++) write_w(k, 17'h04000);
      run_step(16'hFFFF, 17'h0, res, lat);
      check("sat_pos", 32'(res), 32'h0FFFF);
      write_w(15, 17'h1C000);
      run_step(16'hFFFF, 17'h0, res, lat);
      check("sat_pull_back", 32'(res), 32'h0BFFF);

      write_w(0, 17'h10000);
      write_w(1, 17'h1FF00);
      run_step(16'h0003, 17'h0, res, lat);
      check("sat_neg", 32'(res), 32'h10000);

      for (int k = 0; k < N_PRE; k++) write_w(k, 17'($signed(11'($urandom))));
      fv = N_PRE'($urandom);
      b  = 17'($signed(12'($urandom)));
      exp_v = model(fv, b);
      bus.fired_vec  = fv;
      bus.bias       = b;
      bus.step_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_busy", 32'(bus.busy), 32'h1);
      check("bp_not_ready", 32'(bus.step_ready), 32'h0);
      wait_valid(lat);
      check("bp_first_latency", 32'(lat), 32'(LAT));
      check("bp_first_i_out", 32'(bus.i_out), 32'(exp_v));
      @(posedge clk); #1;
      gap = 1;
      while (!bus.i_valid && gap < 100) begin
         @(posedge clk); #1;
         gap++;
      end
      bus.step_valid = 1'b0;
      check("bp_period", 32'(gap), 32'(N_PRE + 2));
      check("bp_second_i_out", 32'(bus.i_out), 32'(exp_v));
      @(posedge clk); #1;

      fv = 16'hFFFF;
      b  = 17'h00100;
      exp_v = model(fv, b);
      bus.fired_vec  = fv;
      bus.bias       = b;
      bus.step_valid = 1'b1;
      @(posedge clk); #1;
      bus.step_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(7);
      bus.wr_data = 17'(wm[7] + 256);
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      wait_valid(lat);
      check("collide_old_weight", 32'(bus.i_out), 32'(exp_v));
      wm[7] = wm[7] + 256;
      run_step(fv, b, res, lat);
      check("collide_new_weight", 32'(res), 32'(model(fv, b)));

      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 3; j++) write_w(int'($urandom_range(N_PRE - 1, 0)), 17'($urandom));
         fv = N_PRE'($urandom);
         b  = 17'($urandom);
         exp_v = model(fv, b);
         run_step(fv, b, res, lat);
         check($sformatf("rand_i_out_%0d", r), 32'(res), 32'(exp_v));
         check($sformatf("rand_latency_%0d", r), 32'(lat), 32'(LAT));
      end

      bus.fired_vec  = 16'hFFFF;
      bus.bias       = 17'h00500;
      bus.step_valid = 1'b1;
      @(posedge clk); #1;
      bus.step_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      asyn_reset = 1'b1;
      #1;
      check("midreset_i_out", 32'(bus.i_out), 32'h0);
      check("midreset_busy", 32'(bus.busy), 32'h0);
      check("midreset_ready", 32'(bus.step_ready), 32'h1);
      @(posedge clk); #1;
      asyn_reset = 1'b0;
      for (int k = 0; k < N_PRE; k++) wm[k] = 0;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus.i_valid) pulses++;
      end
      check("midreset_no_valid", 32'(pulses), 32'h0);
      check("midreset_i_out_hold", 32'(bus.i_out), 32'h0);
      run_step(16'hFFFF, 17'h00123, res, lat);
      check("midreset_weights_cleared", 32'(res), 32'(model(16'hFFFF, 17'h00123)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
